// File: rtl/seqgen_101_if.sv
// Word-input handshake bundle for seqgen_101: valid/ready plus payload and length.
interface seqgen_101_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned LW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LW-1:0]    in_len;

   // Producer side offers words; the serializer accepts them.
   modport master (output in_valid, output in_data, output in_len, input in_ready);
   modport slave  (input in_valid, input in_data, input in_len, output in_ready);
endinterface

// File: rtl/seqgen_101.sv
// seqgen_101: serial "101"-pattern transmitter. Accepts a word over valid/ready,
// shifts the low L bits out MSB-first on x (one per clock), then idles GAP cycles.
// Optional macro SEQGEN_EXPECT_EN adds exp_y, a reference overlapping-101 detector
// that follows x with the same one-cycle registered latency as the real detector.
module seqgen_101 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   seqgen_101_if.slave in_if,
   output logic        x,
   output logic        x_valid,
   output logic        busy,
   output logic        done
`ifdef SEQGEN_EXPECT_EN
   ,
   output logic        exp_y
`endif
);

   localparam int unsigned LW = $clog2(WIDTH + 1);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LW-1:0]    bitcnt_q, bitcnt_d;
   logic [GW-1:0]    gapcnt_q, gapcnt_d;

   logic [LW-1:0]    len_eff;
   logic [LW-1:0]    lsh;

   // Effective length: 0 and anything above WIDTH both mean a full word.
   always_comb begin
      len_eff = in_if.in_len;
      if ((in_if.in_len == '0) || (in_if.in_len > LW'(WIDTH))) begin
         len_eff = LW'(WIDTH);
      end
      lsh = LW'(WIDTH) - len_eff;
   end

   // State and datapath registers; reset aborts any word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
      end
   end

   // Next-state logic and Moore output decode from registered state only.
   always_comb begin
      state_d        = state_q;
      shreg_d        = shreg_q;
      bitcnt_d       = bitcnt_q;
      gapcnt_d       = gapcnt_q;
      in_if.in_ready = 1'b0;
      x              = 1'b0;
      x_valid        = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_if.in_ready = 1'b1;
            if (in_if.in_valid) begin
               // Left-justify the field so its MSB sits at the shift-out position.
               shreg_d  = in_if.in_data << lsh;
               bitcnt_d = len_eff - LW'(1);
               state_d  = S_SHIFT;
            end
         end

         S_SHIFT: begin
            x        = shreg_q[WIDTH-1];
            x_valid  = 1'b1;
            busy     = 1'b1;
            done     = (bitcnt_q == '0);
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - LW'(1);
            if (bitcnt_q == '0) begin
               bitcnt_d = '0;
               if (GAP > 0) begin
                  gapcnt_d = GAP_LAST;
                  state_d  = S_GAP;
               end else begin
                  state_d  = S_IDLE;
               end
            end
         end

         S_GAP: begin
            busy = 1'b1;
            if (gapcnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - GW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef SEQGEN_EXPECT_EN
   logic [1:0] hist_q;
   logic       exp_y_q;

   // Reference detector: history spans idle/gap cycles, so patterns can straddle words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q  <= 2'b00;
         exp_y_q <= 1'b0;
      end else begin
         hist_q  <= {hist_q[0], x};
         exp_y_q <= (hist_q == 2'b10) && x;
      end
   end

   assign exp_y = exp_y_q;
`endif

endmodule

// File: doc/seqgen_101.md
Name: seqgen_101

Overview:
- Serial bit-pattern transmitter: the driving end of the serial `x` line consumed by the overlapping "101" sequence detector.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, as a Moore-style output.
- Inserts a fixed idle gap between words.
- Used as the stimulus source for detector benches and as a pattern source in top-level demos.

Parameters:
- WIDTH, 8, maximum word length in bits (>=2).
- GAP, 2, idle cycles (x=0, x_valid=0) after each word before in_ready re-asserts (>=0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word; the low in_len bits are transmitted, MSB of that field first.
- in_len  input  $clog2(WIDTH+1)  bits to send. 0 means WIDTH; values >WIDTH are clamped to WIDTH.
- x  output  1  serial bit stream (to detector input).
- x_valid  output  1  high while x carries a data bit.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse concurrent with the last data bit.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst=0:
  - state=IDLE, shift register and counters cleared.
  - x=0, x_valid=0, busy=0, done=0, in_ready=1 (in_ready comes from state).
- FSM states: IDLE, SHIFT, GAP. All outputs decode from registered state and registers (no input-to-output combinational paths).
- IDLE:
  - in_ready=1, x=0, x_valid=0.
  - On a clk edge with in_valid=1, load shreg = in_data << (WIDTH-L), where L = effective length; set bitcnt = L-1; go to SHIFT.
- SHIFT:
  - x = shreg[WIDTH-1], x_valid=1, busy=1, in_ready=0.
  - Each edge: shift left by 1 (zero fill) and decrement bitcnt.
  - When bitcnt==0, done=1 this cycle. Next state is GAP if GAP>0, else IDLE.
- GAP:
  - x=0, x_valid=0, busy=1, in_ready=0.
  - gapcnt counts GAP cycles, then the FSM returns to IDLE.
- Latency:
  - Handshake captured at edge k; bit 0 is on x during cycle k+1; last bit during cycle k+L.
  - in_ready re-asserts in cycle k+L+GAP+1.
- Boundary conditions:
  - L=1: a single SHIFT cycle; done is asserted in that same cycle.
  - in_valid/in_data/in_len are ignored outside IDLE; no capture and no corruption of the word in flight.
  - Reset asserted mid-word: the word is aborted and outputs go to reset values immediately (asynchronously). After release, the block is in IDLE with in_ready=1.
  - x is held 0 in IDLE and GAP, so a downstream detector sees defined zeros between words.
  - Word boundaries do not reset any pattern history.

Optional Feature:
- Macro: SEQGEN_EXPECT_EN.
- When defined, adds `output exp_y` (1 bit), a built-in reference model of the overlapping 101 detector:
  - A 2-bit history register tracks x every clock, including IDLE and GAP cycles.
  - exp_y is registered, set when history=2'b10 and the current x=1, so it is high the cycle after the completing '1'. This matches the detector's registered y latency.
  - exp_y and the history reset to 0 under rst.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset check: hold rst=0 for 3 cycles with in_valid=1 -> x=0, x_valid=0, busy=0, done=0, in_ready=1. No capture occurs until after release.
2. Full word: in_data=8'b1010_0101, in_len=0, GAP=2 -> x=1,0,1,0,0,1,0,1 on cycles k+1..k+8 with x_valid=1; done only on k+8; x_valid=0 on k+9, k+10; in_ready=1 on k+11.
3. Short word: in_data=8'hFD (low 3 bits 101), in_len=3 -> x=1,0,1 then gap. With SEQGEN_EXPECT_EN: a single exp_y pulse the cycle after the third bit.
4. Overlap: in_data=8'b1010_1010, in_len=8 -> exp_y pulses after bits 3, 5 and 7 (3 pulses). Cross-check against the detector instance driven by x.
5. Busy protection: hold in_valid=1 and toggle in_data every cycle during SHIFT -> in_ready=0, transmitted bits match the first captured word exactly, and the next capture occurs only in IDLE.
6. Mid-word reset: assert rst=0 during bit 4 of 8'hFF -> x, x_valid, busy drop the same cycle. After release in_ready=1, and a new word 8'h05 with in_len=3 transmits 1,0,1 correctly.
